// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   Receives 8N1 frames from the board UART line and presents each completed
//   byte on an 8-bit bus. The bus feeds the downstream nonzero-detect OR
//   reduction and the CPU-side input register.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high reset (priority over everything)
//   rx         asynchronous serial line, idle high
//   data_out   received byte, bit 0 = first data bit on the line
//   valid      data_out holds an unconsumed byte
//   ready      consumer accepts data_out on an edge where valid=1 and ready=1
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: completed byte dropped, previous one unconsumed
//
// Handshake: a byte transfers on every rising edge where valid=1 and ready=1.
// While valid=1, data_out is held stable until that accepting edge; valid may
// stay high across the edge only when a new byte is delivered on that same
// edge. ready has no effect while valid=0.
//
// Timing: every sample point is counted from the first cycle the IDLE state
// sees rx_s low. The start bit is checked CLKS_PER_BIT/2 cycles later, each
// data bit and the stop bit a further CLKS_PER_BIT cycles apart, so all
// samples land at bit centres. Parameter legal range: 4..65535.

module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       ready,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // Registered state
    logic        rx_meta;
    logic        rx_s;
    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shreg_q;

    // Next-state values
    state_t      state_d;
    logic [15:0] cnt_d;
    logic [2:0]  idx_d;
    logic [7:0]  shreg_d;
    logic [7:0]  data_d;
    logic        valid_d;
    logic        frame_err_d;
    logic        overrun_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            idx_q     <= 3'd0;
            shreg_q   <= 8'h00;
            data_out  <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            data_out  <= data_d;
            valid     <= valid_d;
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        data_d      = data_out;
        valid_d     = valid;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Consumer takes the held byte; a delivery below may re-raise valid
        // on the same edge.
        if (valid && ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = 16'd0;
                end
            end

            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    if (rx_s) begin
                        // Line went back high before mid-start: a glitch.
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = 16'd0;
                        idx_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 16'd0;
                    // LSB arrives first, so shift right and insert at bit 7.
                    shreg_d = {rx_s, shreg_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                        if (!valid || ready) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_BREAK: begin
                // Wait out a held-low line so it cannot look like a new start.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte
//   Directed and randomized stimulus for uart_rx_byte at CLKS_PER_BIT=8.
//   Frames are built bit by bit from the 8N1 line format; expected bytes,
//   pulse counts and latency come from that format, not from the design.

module tb_uart_rx_byte;

    localparam int C = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .ready     (ready),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] acc_q[$];   // bytes the consumer actually took
    logic [7:0] exp_q[$];   // bytes the reference model says it should take

    int   fe_cnt    = 0;
    int   ov_cnt    = 0;
    int   both_cnt  = 0;
    int   vhigh_cnt = 0;
    int   rise_cnt  = 0;
    int   rise_cyc  = 0;
    logic valid_prev = 1'b0;

    // Outputs are observed on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid && ready) acc_q.push_back(data_out);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) both_cnt++;
            if (valid) vhigh_cnt++;
            if (valid && !valid_prev) begin
                rise_cnt++;
                rise_cyc = cyc;
            end
        end
        valid_prev = valid;
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'hxx;
        if (acc_q.size() > 0) got = acc_q.pop_front();
        check(tag, {24'd0, got}, {24'd0, exp});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one 8N1 frame. If ready_at >= 0, ready is 1 only on the edge
    // ready_at+1 cycles after the frame starts, 0 on all other frame edges.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ready_at);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10 * C; k++) begin
            rx = bits[k / C];
            if (ready_at >= 0) ready = (k == ready_at);
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    int f0, lat, v0, r0, fe0, ov0;
    logic [7:0] rb;
    logic [7:0] abandoned;

    initial begin
        // Reset state
        tick(3);
        check("reset data_out", {24'd0, data_out}, 32'h00);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        check("reset overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        tick(5);

        // 1: single byte, consumer ready, latency
        ready = 1'b1;
        v0 = vhigh_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        f0 = cyc;
        send_frame(8'hA5, 1'b1, -1);
        tick(4);
        lat = rise_cyc - f0;
        check("t1 latency in 78..80", {31'd0, (lat >= 78 && lat <= 80)}, 32'd1);
        check("t1 accepted count", acc_q.size(), 32'd1);
        check_pop("t1 byte", 8'hA5);
        check("t1 valid high cycles", vhigh_cnt - v0, 32'd1);
        check("t1 frame_err pulses", fe_cnt - fe0, 32'd0);
        check("t1 overrun pulses", ov_cnt - ov0, 32'd0);
        check("t1 valid idle", {31'd0, valid}, 32'd0);

        // 2: consumer stalled, second byte overruns
        ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h3C, 1'b1, -1);
        send_frame(8'h00, 1'b1, -1);
        tick(4);
        check("t2 data held", {24'd0, data_out}, 32'h3C);
        check("t2 valid held", {31'd0, valid}, 32'd1);
        check("t2 overrun pulses", ov_cnt - ov0, 32'd1);
        check("t2 nothing accepted", acc_q.size(), 32'd0);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check_pop("t2 accepted byte", 8'h3C);
        check("t2 valid drops", {31'd0, valid}, 32'd0);
        check("t2 data_out holds", {24'd0, data_out}, 32'h3C);

        // 3: delivery on the same edge as acceptance
        ov0 = ov_cnt;
        r0 = rise_cnt;
        send_frame(8'h81, 1'b1, -1);
        // valid for the next frame rises after edge 79; ready only on that edge
        send_frame(8'h7E, 1'b1, 78);
        ready = 1'b0;
        tick(2);
        check("t3 data_out new", {24'd0, data_out}, 32'h7E);
        check("t3 valid stays", {31'd0, valid}, 32'd1);
        check("t3 overrun pulses", ov_cnt - ov0, 32'd0);
        check("t3 valid rises once", rise_cnt - r0, 32'd1);
        check_pop("t3 first byte taken", 8'h81);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check_pop("t3 second byte taken", 8'h7E);
        check("t3 valid drops", {31'd0, valid}, 32'd0);

        // 4: short glitch rejected
        fe0 = fe_cnt; r0 = rise_cnt;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        check("t4 no valid", rise_cnt - r0, 32'd0);
        check("t4 no frame_err", fe_cnt - fe0, 32'd0);
        ready = 1'b1;
        send_frame(8'h55, 1'b1, -1);
        tick(4);
        check_pop("t4 byte after glitch", 8'h55);

        // 5: framing error with held-low line
        fe0 = fe_cnt; r0 = rise_cnt; ov0 = ov_cnt;
        send_frame(8'hFF, 1'b0, -1);
        tick(40);
        rx = 1'b1;
        tick(20);
        check("t5 frame_err pulses", fe_cnt - fe0, 32'd1);
        check("t5 no valid", rise_cnt - r0, 32'd0);
        check("t5 no overrun", ov_cnt - ov0, 32'd0);
        check("t5 nothing accepted", acc_q.size(), 32'd0);
        send_frame(8'h12, 1'b1, -1);
        tick(4);
        check_pop("t5 byte after break", 8'h12);

        // 6: reset during data bit 4
        abandoned = 8'h5A;
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            rx = abandoned[i];
            tick(C);
        end
        rx = abandoned[4];
        tick(C / 2);
        reset = 1'b1;
        rx = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6 data_out reset", {24'd0, data_out}, 32'h00);
        check("t6 valid reset", {31'd0, valid}, 32'd0);
        check("t6 frame_err reset", {31'd0, frame_err}, 32'd0);
        check("t6 overrun reset", {31'd0, overrun}, 32'd0);
        fe0 = fe_cnt; r0 = rise_cnt; ov0 = ov_cnt;
        tick(100);
        check("t6 no valid after abandon", rise_cnt - r0, 32'd0);
        check("t6 no pulses after abandon", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);
        send_frame(8'hC3, 1'b1, -1);
        tick(4);
        check_pop("t6 byte after reset", 8'hC3);

        // 7: random bytes with random idle gaps; an always-ready consumer
        // must take every well-formed frame in order.
        ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            rb = 8'($urandom_range(0, 255));
            exp_q.push_back(rb);
            send_frame(rb, 1'b1, -1);
            tick($urandom_range(0, 6));
        end
        tick(5);
        check("t7 accepted count", acc_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            check_pop("t7 random byte", exp_q.pop_front());
        end

        check("frame_err and overrun together", both_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial-to-parallel receive stage for the board's UART line.
- Assembles 8N1 frames into 8-bit bytes and presents them on an 8-bit bus with a valid/ready handshake.
- The byte bus feeds the downstream 8-way OR reduction, which produces the "received byte is nonzero" flag, and the CPU-side input register.
- Sits directly upstream of that reduction stage.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Legal range is 4..65535. Internal counter is 16 bits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- data_out  output  8  received byte, bit 0 = first data bit on the line
- valid  output  1  data_out holds an unconsumed byte
- ready  input  1  consumer accepts data_out on a clk edge where valid=1 and ready=1
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: completed byte dropped because the previous byte was still unconsumed

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. Reset has priority over all other logic.
- Reset values:
  - data_out=8'h00, valid=0, frame_err=0, overrun=0.
  - Synchronizer flops=1, state=IDLE, baud counter=0, bit index=0, shift register=0.
  - Reset mid-frame abandons the frame with no output pulse.
- Input synchronizer:
  - rx passes through 2 flops to give rx_s. All FSM decisions use rx_s only.
  - rx_s lags rx by 2 cycles.
- FSM states:
  - IDLE:
    - rx_s=0 -> START, counter cleared.
  - START:
    - Count to CLKS_PER_BIT/2 (integer divide), then sample rx_s.
    - rx_s=1 -> IDLE. Glitch rejected, no pulse.
    - rx_s=0 -> DATA, counter cleared, bit index=0.
  - DATA:
    - Every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first (shift right, new bit into bit 7).
    - After the 8th sample -> STOP.
  - STOP:
    - After CLKS_PER_BIT cycles, sample rx_s.
    - rx_s=1 -> deliver the byte (see below), then IDLE.
    - rx_s=0 -> frame_err=1 for exactly one cycle, byte discarded, -> BREAK.
  - BREAK:
    - Stay until rx_s=1, then IDLE. This prevents retriggering on a held-low line.
- Sample points: all samples fall at bit centres, measured from the first cycle rx_s=0 is seen in IDLE.
- Delivery, on the cycle after the stop sample:
  - valid=0, or valid=1 with ready=1 on that same edge: data_out loads the new byte, valid=1.
  - valid=1 with ready=0: new byte dropped, data_out and valid unchanged, overrun=1 for one cycle.
- Handshake:
  - Once valid=1, data_out stays stable until the accepting edge.
  - On an edge with valid=1 and ready=1 and no simultaneous delivery, valid drops to 0 on the next cycle and data_out holds its last value.
  - ready while valid=0 has no effect.
- Latency: valid rises 1 cycle after the stop-bit centre sample. That is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx falling edge, ±1 for synchronizer phase.
- Back-to-back frames:
  - A start bit that begins immediately after the stop-bit centre is received correctly.
  - IDLE is entered in the cycle after the stop sample.
- frame_err and overrun are never asserted in the same cycle.

Test Plan:
- CLKS_PER_BIT=8, ready=1, send 8'hA5 as 8N1 -> valid pulses one cycle with data_out=8'hA5. frame_err=0, overrun=0. valid rise within ±1 cycle of the latency formula (79 cycles after the edge).
- ready=0, send 8'h3C then 8'h00 back-to-back -> data_out=8'h3C, valid held high. overrun pulses once at the second stop sample. Raising ready then yields data_out still 8'h3C, and valid falls next cycle.
- ready=0, send 8'h81. At the cycle valid rises, deliver 8'h7E with ready=1 on the same edge -> data_out=8'h7E, valid stays 1, overrun=0.
- rx low pulse of 3 cycles (less than CLKS_PER_BIT/2) -> no valid, no frame_err, FSM back in IDLE. A following 8'h55 is received correctly.
- Send 8'hFF with stop bit forced 0, rx held low 40 cycles, then high -> single frame_err pulse, no valid, no retrigger. A following 8'h12 is received correctly.
- Assert reset for 1 cycle during data bit 4 of a frame -> all outputs return to reset values next cycle, no valid or pulse for the abandoned frame. The next full frame 8'hC3 is received correctly.
